io_response_interface: RTL

- Return-path counterpart of the IO command interface. Accepts one wide response word (PORTBYTEWIDTH*8 bits) from an IO port and serializes it into DATABITWIDTH-bit words for the core writeback path, least-significant word first.
- Sits between the IO port response bus and the core load/writeback arbiter.
- Holds one response at a time. Accepts the next response in the same cycle the last word is handed off.

---
 rtl/io_pkg.sv | 21 ++
 rtl/io_response_interface.sv | 103 ++++++++++
 2 files changed

// File: rtl/io_pkg.sv
// Shared types and sizing helpers for the IO command/response interfaces.
package io_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } io_state_t;

    // Number of core words needed to carry one port word.
    function automatic int calc_buffercount(input int dataBitWidth, input int portByteWidth);
        if (portByteWidth * 8 <= dataBitWidth) begin
            return 1;
        end
        return (portByteWidth * 8) / dataBitWidth;
    endfunction

    function automatic int calc_counterwidth(input int bufferCount);
        return (bufferCount > 1) ? $clog2(bufferCount) : 1;
    endfunction

endpackage

// File: rtl/io_response_interface.sv
// Captures one wide IO port response and hands it to the core writeback path
// as DATABITWIDTH-bit words, least-significant word first.
module io_response_interface
    import io_pkg::*;
#(
    parameter int  DATABITWIDTH  = 16,
    parameter int  PORTBYTEWIDTH = 8,
    parameter int  TAGBITWIDTH   = 4,
    localparam int BUFFERCOUNT   = calc_buffercount(DATABITWIDTH, PORTBYTEWIDTH),
    localparam int COUNTERWIDTH  = calc_counterwidth(BUFFERCOUNT)
) (
    input  logic                       clk,
    input  logic                       async_rst_n,
    input  logic                       clk_en,
    input  logic                       IORespREQ,
    output logic                       IORespACK,
    input  logic [PORTBYTEWIDTH*8-1:0] RespDataIn,
    input  logic [TAGBITWIDTH-1:0]     RespTagIn,
    output logic                       WordOutValid,
    input  logic                       WordOutReady,
    output logic [DATABITWIDTH-1:0]    WordOut,
    output logic [COUNTERWIDTH-1:0]    WordIndex,
    output logic                       WordLast,
    output logic [TAGBITWIDTH-1:0]     TagOut,
    output logic                       Busy
);

    localparam int PORTBITWIDTH   = PORTBYTEWIDTH * 8;
    localparam int BUFFERBITWIDTH = BUFFERCOUNT * DATABITWIDTH;
    localparam logic [COUNTERWIDTH-1:0] LAST_INDEX = COUNTERWIDTH'(BUFFERCOUNT - 1);

    io_state_t                   state_reg;
    logic [BUFFERBITWIDTH-1:0]   buffer_reg;
    logic [TAGBITWIDTH-1:0]      tag_reg;
    logic [COUNTERWIDTH-1:0]     counter_reg;

    logic [BUFFERBITWIDTH-1:0]   resp_padded;
    logic [DATABITWIDTH-1:0]     selected_word;
    logic                        out_fire;
    logic                        resp_fire;

    // A port narrower than one core word lands zero-extended in the buffer.
    always_comb begin
        resp_padded = '0;
        resp_padded[PORTBITWIDTH-1:0] = RespDataIn;
    end

    assign selected_word = buffer_reg[counter_reg * DATABITWIDTH +: DATABITWIDTH];

    assign Busy         = (state_reg == DRAIN);
    assign WordOutValid = Busy;
    assign WordOut      = Busy ? selected_word : '0;
    assign WordIndex    = counter_reg;
    assign WordLast     = Busy && (counter_reg == LAST_INDEX);
    assign TagOut       = tag_reg;

    assign out_fire  = WordOutValid && WordOutReady && clk_en;
    // Accepting on the final handoff lets back-to-back responses stream with no idle cycle.
    assign IORespACK = clk_en && async_rst_n &&
                       ((state_reg == IDLE) || (out_fire && WordLast));
    assign resp_fire = IORespREQ && IORespACK;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_reg   <= IDLE;
            buffer_reg  <= '0;
            tag_reg     <= '0;
            counter_reg <= '0;
        end else if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    if (resp_fire) begin
                        buffer_reg  <= resp_padded;
                        tag_reg     <= RespTagIn;
                        counter_reg <= '0;
                        state_reg   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (counter_reg == LAST_INDEX) begin
                            counter_reg <= '0;
                            if (resp_fire) begin
                                buffer_reg <= resp_padded;
                                tag_reg    <= RespTagIn;
                                state_reg  <= DRAIN;
                            end else begin
                                state_reg  <= IDLE;
                            end
                        end else begin
                            counter_reg <= counter_reg + COUNTERWIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    counter_reg <= '0;
                end
            endcase
        end
    end

endmodule
